// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Brief    : Shared screen geometry, ball constants and game FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int V_MIN    = 32;
  localparam int V_MAX    = 448;
  localparam int BALL_R   = 16;

  // Ball-engine reset centre
  localparam int CENTER_X = 320;
  localparam int CENTER_Y = 240;

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    MISS_HOLD = 2'd2,
    OVER      = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync
// Brief    : Two-flop synchroniser for a raw button with rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Two-stage synchroniser followed by a delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule
`default_nettype wire

// File: rtl/paddle_engine.sv
`default_nettype none
// ============================================================================
// Module   : paddle_engine
// Brief    : Player paddle on the left wall: movement, hit/miss judgement,
//            lives/score keeping and ball-engine hold control.
// Revision : 1.0 - initial release
// ============================================================================
module paddle_engine #(
  parameter int WALL_X      = 16,
  parameter int PAD_LEN     = 96,
  parameter int PAD_STEP    = 4,
  parameter int PAD_MIN     = 16,
  parameter int PAD_MAX     = 464,
  parameter int BALL_R      = pong_pkg::BALL_R,
  parameter int LIVES       = 3,
  parameter int HOLD_FRAMES = 60,
  parameter int TICK_V      = 480
) (
  input  logic       PixClk,
  input  logic       enable,
  input  logic [9:0] Hcounter,
  input  logic [9:0] Vcounter,
  input  logic [9:0] Hcen,
  input  logic [9:0] Vcen,
  input  logic       BtnUp,
  input  logic       BtnDn,
  output logic [9:0] HWall,
  output logic       BallEn,
  output logic       PadOn,
  output logic [7:0] Score,
  output logic [1:0] Lives,
  output logic       GameOver
);

  import pong_pkg::*;

  localparam int         CNT_W      = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [9:0] PAD_LO     = 10'(PAD_MIN);
  localparam logic [9:0] PAD_HI     = 10'(PAD_MAX - PAD_LEN);
  localparam logic [9:0] STEP       = 10'(PAD_STEP);
  localparam logic [9:0] PAD_RESET  = 10'(CENTER_Y - PAD_LEN / 2);
  localparam logic [9:0] LEN_M1     = 10'(PAD_LEN - 1);
  localparam logic [9:0] ARRIVE_X   = 10'(WALL_X + 16);
  localparam logic [9:0] ARM_X      = 10'(WALL_X + 64);
  localparam logic [9:0] PADON_X0   = 10'(WALL_X - 8);
  localparam logic [9:0] PADON_X1   = 10'(WALL_X - 1);
  localparam logic [9:0] TICK_LINE  = 10'(TICK_V);
  localparam logic [10:0] BR11      = 11'(BALL_R);
  localparam logic [10:0] LEN11_M1  = 11'(PAD_LEN - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] frame_cnt;
  logic [9:0]       pad_top;
  logic [7:0]       score;
  logic [1:0]       lives;
  logic             armed;
  logic             ball_en;
  logic             pad_on;
  logic             tick;

  logic up_lvl, up_rise, dn_lvl, dn_rise;
  logic hit, miss, restart;
  logic arrive, in_window, hold_done;
  logic [10:0] vc11, pt11;

  btn_sync u_sync_up (
    .clk   (PixClk),
    .rst_n (enable),
    .btn   (BtnUp),
    .level (up_lvl),
    .rise  (up_rise)
  );

  btn_sync u_sync_dn (
    .clk   (PixClk),
    .rst_n (enable),
    .btn   (BtnDn),
    .level (dn_lvl),
    .rise  (dn_rise)
  );

  // Widen to 11 bits so Vcen+BALL_R and PadTop+PAD_LEN never overflow
  assign vc11      = {1'b0, Vcen};
  assign pt11      = {1'b0, pad_top};
  assign in_window = ((vc11 + BR11) >= pt11) && (vc11 <= (pt11 + LEN11_M1 + BR11));
  assign arrive    = armed && (Hcen <= ARRIVE_X);
  assign hold_done = tick && (frame_cnt == CNT_LAST);

  // Frame tick: one registered pulse at the start of vblank
  always_ff @(posedge PixClk or negedge enable) begin
    if (!enable) tick <= 1'b0;
    else         tick <= (Hcounter == 10'd0) && (Vcounter == TICK_LINE);
  end

  // Game state register
  always_ff @(posedge PixClk or negedge enable) begin
    if (!enable) state <= SERVE;
    else         state <= next_state;
  end

  // Next-state logic and single-cycle game events
  always_comb begin
    next_state = state;
    hit        = 1'b0;
    miss       = 1'b0;
    restart    = 1'b0;
    case (state)
      SERVE: begin
        if (hold_done) next_state = PLAY;
      end
      PLAY: begin
        if (arrive) begin
          if (in_window) begin
            hit = 1'b1;
          end else begin
            miss       = 1'b1;
            next_state = MISS_HOLD;
          end
        end
      end
      MISS_HOLD: begin
        if (hold_done) next_state = (lives == 2'd0) ? OVER : PLAY;
      end
      OVER: begin
        if (up_rise || dn_rise) begin
          restart    = 1'b1;
          next_state = SERVE;
        end
      end
      default: next_state = SERVE;
    endcase
  end

  // Hold-frame counter: restarts on every state change, counts ticks only while holding
  always_ff @(posedge PixClk or negedge enable) begin
    if (!enable) begin
      frame_cnt <= '0;
    end else if (next_state != state) begin
      frame_cnt <= '0;
    end else if (tick && (state == SERVE || state == MISS_HOLD)) begin
      frame_cnt <= frame_cnt + CNT_ONE;
    end
  end

  // Score, lives and the one-judgement-per-approach arm flag
  always_ff @(posedge PixClk or negedge enable) begin
    if (!enable) begin
      score <= 8'd0;
      lives <= LIVES_INIT;
      armed <= 1'b1;
    end else begin
      if (restart) begin
        score <= 8'd0;
        lives <= LIVES_INIT;
      end
      if (hit && score != 8'hFF) score <= score + 8'd1;
      if (miss && lives != 2'd0) lives <= lives - 2'd1;
      if (hit || miss) begin
        armed <= 1'b0;
      end else if ((next_state == PLAY && state != PLAY) || (Hcen >= ARM_X)) begin
        armed <= 1'b1;
      end
    end
  end

  // Paddle motion once per frame, saturating at both bounds, frozen in OVER
  always_ff @(posedge PixClk or negedge enable) begin
    if (!enable) begin
      pad_top <= PAD_RESET;
    end else if (tick && state != OVER) begin
      if (up_lvl && !dn_lvl) begin
        pad_top <= (pad_top < PAD_LO + STEP) ? PAD_LO : pad_top - STEP;
      end else if (dn_lvl && !up_lvl) begin
        pad_top <= (pad_top > PAD_HI - STEP) ? PAD_HI : pad_top + STEP;
      end
    end
  end

  // Registered outputs: ball enable follows PLAY, paddle pixel from raster position
  always_ff @(posedge PixClk or negedge enable) begin
    if (!enable) begin
      ball_en <= 1'b0;
      pad_on  <= 1'b0;
    end else begin
      ball_en <= (state == PLAY);
      pad_on  <= (Hcounter >= PADON_X0) && (Hcounter <= PADON_X1) &&
                 (Vcounter >= pad_top) && (Vcounter <= pad_top + LEN_M1);
    end
  end

  assign HWall    = 10'(WALL_X);
  assign BallEn   = ball_en;
  assign PadOn    = pad_on;
  assign Score    = score;
  assign Lives    = lives;
  assign GameOver = (state == OVER);

endmodule
`default_nettype wire

// File: tb/tb_paddle_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_paddle_engine
// Brief    : Directed self-checking bench for paddle_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paddle_engine;

  logic       PixClk = 1'b0;
  logic       enable;
  logic [9:0] Hcounter, Vcounter, Hcen, Vcen;
  logic       BtnUp, BtnDn;
  logic [9:0] HWall;
  logic       BallEn, PadOn, GameOver;
  logic [7:0] Score;
  logic [1:0] Lives;

  int checks = 0;
  int errors = 0;

  paddle_engine dut (
    .PixClk   (PixClk),
    .enable   (enable),
    .Hcounter (Hcounter),
    .Vcounter (Vcounter),
    .Hcen     (Hcen),
    .Vcen     (Vcen),
    .BtnUp    (BtnUp),
    .BtnDn    (BtnDn),
    .HWall    (HWall),
    .BallEn   (BallEn),
    .PadOn    (PadOn),
    .Score    (Score),
    .Lives    (Lives),
    .GameOver (GameOver)
  );

  always #5 PixClk = ~PixClk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge PixClk);
      #1;
    end
  endtask

  // One frame tick: raster at (0, 480) for one cycle, then the tick edge
  task automatic ticks(input int n);
    repeat (n) begin
      Hcounter = 10'd0;
      Vcounter = 10'd480;
      step();
      Hcounter = 10'd5;
      Vcounter = 10'd0;
      step();
    end
  endtask

  // Locate the paddle through PadOn at its top and bottom edges
  task automatic probe(input string tag, input int top);
    Hcounter = 10'd8;  Vcounter = 10'(top - 1);  step();
    check({tag, "_above"}, PadOn, 0);
    Vcounter = 10'(top);       step();
    check({tag, "_top"}, PadOn, 1);
    Hcounter = 10'd15; Vcounter = 10'(top + 95); step();
    check({tag, "_bot"}, PadOn, 1);
    Vcounter = 10'(top + 96);  step();
    check({tag, "_below"}, PadOn, 0);
    Hcounter = 10'd5;  Vcounter = 10'd0;
  endtask

  task automatic ramp();
    for (int h = 300; h >= 32; h -= 4) begin
      Hcen = 10'(h);
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b0; BtnUp = 1'b0; BtnDn = 1'b0;
    Hcounter = 10'd5; Vcounter = 10'd0; Hcen = 10'd300; Vcen = 10'd240;
    step(2);
    check("rst_ballen", BallEn, 0);
    check("rst_score", Score, 0);
    check("rst_lives", Lives, 3);
    check("rst_over", GameOver, 0);
    check("rst_hwall", HWall, 16);
    check("rst_padon", PadOn, 0);
    check("rst_state", int'(dut.state), 0);
    enable = 1'b1;
    step();
    probe("pad_rst", 192);

    // PadOn horizontal limits
    Hcounter = 10'd7;  Vcounter = 10'd200; step(); check("padon_x7", PadOn, 0);
    Hcounter = 10'd16; step(); check("padon_x16", PadOn, 0);
    Hcounter = 10'd5;  Vcounter = 10'd0;

    // Move up: 10 ticks to 152, then clamp at 16 (50 ticks in SERVE total)
    BtnUp = 1'b1; step(3);
    ticks(1);  probe("pad_up1", 188);
    ticks(9);  probe("pad_up10", 152);
    ticks(40); probe("pad_clamp", 16);
    check("serve_ballen", BallEn, 0);
    check("serve_state", int'(dut.state), 0);

    // Move down; SERVE ends exactly on the 60th tick
    BtnUp = 1'b0; BtnDn = 1'b1; step(3);
    ticks(9); check("serve59_state", int'(dut.state), 0);
    ticks(1); check("serve60_state", int'(dut.state), 1);
    step();   check("play_ballen", BallEn, 1);
    ticks(34);
    BtnDn = 1'b0; step(3);
    probe("pad_back", 192);

    // Hit in the middle of the paddle, then hold at the wall
    Vcen = 10'd200; ramp();
    check("hit1_score", Score, 1);
    check("hit1_state", int'(dut.state), 1);
    check("hit1_lives", Lives, 3);
    step(10);
    check("hit1_once", Score, 1);
    Hcen = 10'd300; step();

    // Hit window edges: PadTop-BALL_R and PadTop+PAD_LEN-1+BALL_R
    Vcen = 10'd176; ramp(); check("hit_lo_edge", Score, 2);
    Hcen = 10'd300; step();
    Vcen = 10'd303; ramp(); check("hit_hi_edge", Score, 3);
    Hcen = 10'd300; step();

    // Miss 1: state and lives after one cycle, BallEn after two
    Vcen = 10'd400; Hcen = 10'd32; step();
    check("miss1_state", int'(dut.state), 2);
    check("miss1_lives", Lives, 2);
    check("miss1_ballen_lag", BallEn, 1);
    step();
    check("miss1_ballen", BallEn, 0);
    Hcen = 10'd300;
    ticks(59);
    check("hold59_ballen", BallEn, 0);
    check("hold59_state", int'(dut.state), 2);
    ticks(1);
    check("hold60_state", int'(dut.state), 1);
    step();
    check("hold60_ballen", BallEn, 1);

    // Miss 2 just outside the window
    Vcen = 10'd175; Hcen = 10'd32; step();
    check("miss2_lives", Lives, 1);
    check("miss2_score", Score, 3);
    Hcen = 10'd300; ticks(60);
    check("miss2_play", int'(dut.state), 1);

    // Miss 3 ends the game
    Vcen = 10'd400; Hcen = 10'd32; step();
    check("miss3_lives", Lives, 0);
    Hcen = 10'd300; ticks(60);
    check("over_flag", GameOver, 1);
    check("over_state", int'(dut.state), 3);
    step(); ticks(5);
    check("over_ballen", BallEn, 0);
    check("over_stays", GameOver, 1);

    // Restart via BtnDn
    BtnDn = 1'b1; step(3);
    check("restart_lives", Lives, 3);
    check("restart_score", Score, 0);
    check("restart_state", int'(dut.state), 0);
    check("restart_over", GameOver, 0);
    BtnDn = 1'b0; step(3);

    // Play again, score once, then miss and reset mid-hold
    ticks(60);
    step();
    Vcen = 10'd200; Hcen = 10'd32; step();
    check("replay_score", Score, 1);
    Hcen = 10'd300; step();
    Vcen = 10'd400; Hcen = 10'd32; step();
    check("replay_miss", int'(dut.state), 2);
    Hcen = 10'd300; ticks(10);
    #2 enable = 1'b0;
    #1;
    check("arst_ballen", BallEn, 0);
    check("arst_score", Score, 0);
    check("arst_lives", Lives, 3);
    check("arst_over", GameOver, 0);
    check("arst_state", int'(dut.state), 0);
    check("arst_padon", PadOn, 0);
    step(2);
    enable = 1'b1; step();

    // Both buttons held: no motion
    BtnUp = 1'b1; BtnDn = 1'b1; step(3);
    ticks(5);
    probe("pad_both", 192);
    BtnUp = 1'b0; BtnDn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
